// File: rtl/escalator_motor_driver.sv
// Escalator motor driver: direction command in, ramped speed / direction /
// enable / brake out. Never reverses while moving; estop and invalid-command
// faults latch until reset.
// Optional build macro: ESCALATOR_DRV_CMD_FILTER_EN (debounce on direction).
module escalator_motor_driver #(
    parameter int unsigned SPEED_W    = 8,
    parameter int unsigned MAX_SPEED  = 200,
    parameter int unsigned RAMP_STEP  = 4,
    parameter int unsigned RAMP_DIV   = 10,
    parameter int unsigned BRAKE_HOLD = 20,
    parameter int unsigned CMD_STABLE = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         direction,
    input  logic               estop,
    output logic [SPEED_W-1:0] speed,
    output logic               motor_dir,
    output logic               motor_en,
    output logic               brake,
    output logic               at_speed,
    output logic               fault
);

    localparam int unsigned PRE_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned HOLD_W = (BRAKE_HOLD > 1) ? $clog2(BRAKE_HOLD) : 1;
    localparam int unsigned SW1    = SPEED_W + 1;

    localparam logic [SW1-1:0]    MAX_EXT   = SW1'(MAX_SPEED);
    localparam logic [SW1-1:0]    STEP_EXT  = SW1'(RAMP_STEP);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(RAMP_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(BRAKE_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEL,
        S_RUN,
        S_DECEL,
        S_HOLD,
        S_FAULT
    } state_t;

    state_t              r_state;
    logic [SPEED_W-1:0]  r_speed;
    logic                r_dir;
    logic                r_en;
    logic                r_brake;
    logic                r_at_speed;
    logic                r_fault;
    logic                r_fault_pending;
    logic [PRE_W-1:0]    r_presc;
    logic [HOLD_W-1:0]   r_hold;

    logic [1:0]          w_cmd;
    logic                w_tick;
    logic [SW1-1:0]      w_up_sum;
    logic [SW1-1:0]      w_up;
    logic [SW1-1:0]      w_dn;
    logic [1:0]          w_cmd_dir;
    logic                w_cmd_bad;
    logic                w_cmd_run;

`ifdef ESCALATOR_DRV_CMD_FILTER_EN
    localparam int unsigned FLT_W = (CMD_STABLE > 1) ? $clog2(CMD_STABLE + 1) : 1;

    logic [1:0]       r_flt_cand;
    logic [1:0]       r_flt_acc;
    logic [FLT_W-1:0] r_flt_cnt;
    logic [FLT_W-1:0] w_flt_cnt_nxt;

    assign w_flt_cnt_nxt = (direction == r_flt_cand) ? (r_flt_cnt + FLT_W'(1)) : FLT_W'(1);

    // Debounce: accept a new command once it has been seen CMD_STABLE cycles in a row
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flt_cand <= 2'b00;
            r_flt_acc  <= 2'b00;
            r_flt_cnt  <= '0;
        end else begin
            r_flt_cand <= direction;
            if (direction == r_flt_acc) begin
                r_flt_cnt <= '0;
            end else if (w_flt_cnt_nxt >= FLT_W'(CMD_STABLE)) begin
                r_flt_acc <= direction;
                r_flt_cnt <= '0;
            end else begin
                r_flt_cnt <= w_flt_cnt_nxt;
            end
        end
    end

    assign w_cmd = r_flt_acc;
`else
    localparam int unsigned cmd_stable_unused = CMD_STABLE;
    assign w_cmd = direction;
`endif

    // Ramp arithmetic one bit wider than speed, saturating at both ends
    assign w_tick    = (r_presc == PRE_LAST);
    assign w_up_sum  = {1'b0, r_speed} + STEP_EXT;
    assign w_up      = (w_up_sum >= MAX_EXT) ? MAX_EXT : w_up_sum;
    assign w_dn      = ({1'b0, r_speed} > STEP_EXT) ? ({1'b0, r_speed} - STEP_EXT) : '0;
    assign w_cmd_dir = r_dir ? 2'b01 : 2'b10;
    assign w_cmd_bad = (w_cmd == 2'b11);
    assign w_cmd_run = (w_cmd == w_cmd_dir);

    // Main FSM with registered outputs; estop overrides every state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_speed         <= '0;
            r_dir           <= 1'b0;
            r_en            <= 1'b0;
            r_brake         <= 1'b1;
            r_at_speed      <= 1'b0;
            r_fault         <= 1'b0;
            r_fault_pending <= 1'b0;
            r_presc         <= '0;
            r_hold          <= '0;
        end else if (estop) begin
            r_state    <= S_FAULT;
            r_speed    <= '0;
            r_en       <= 1'b0;
            r_brake    <= 1'b1;
            r_at_speed <= 1'b0;
            r_fault    <= 1'b1;
            r_presc    <= '0;
            r_hold     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_presc <= '0;
                    r_hold  <= '0;
                    if (w_cmd_bad) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end else if (w_cmd != 2'b00) begin
                        r_dir           <= (w_cmd == 2'b01);
                        r_state         <= S_ACCEL;
                        r_brake         <= 1'b0;
                        r_en            <= 1'b1;
                        r_fault_pending <= 1'b0;
                    end
                end
                S_ACCEL: begin
                    if (!w_cmd_run) begin
                        r_state <= S_DECEL;
                        r_presc <= '0;
                        if (w_cmd_bad) r_fault_pending <= 1'b1;
                    end else if (w_tick) begin
                        r_speed <= w_up[SPEED_W-1:0];
                        r_presc <= '0;
                        if (w_up == MAX_EXT) begin
                            r_state    <= S_RUN;
                            r_at_speed <= 1'b1;
                        end
                    end else begin
                        r_presc <= r_presc + PRE_W'(1);
                    end
                end
                S_RUN: begin
                    if (!w_cmd_run) begin
                        r_state    <= S_DECEL;
                        r_at_speed <= 1'b0;
                        r_presc    <= '0;
                        if (w_cmd_bad) r_fault_pending <= 1'b1;
                    end
                end
                S_DECEL: begin
                    if (w_cmd_bad) r_fault_pending <= 1'b1;
                    // Once an invalid command was seen, the ramp-down is committed to FAULT
                    if (w_cmd_run && !r_fault_pending) begin
                        r_state <= S_ACCEL;
                        r_presc <= '0;
                    end else if ((r_speed == '0) || (w_tick && (w_dn == '0))) begin
                        r_speed <= '0;
                        r_brake <= 1'b1;
                        r_en    <= 1'b0;
                        r_presc <= '0;
                        r_hold  <= '0;
                        if (r_fault_pending || w_cmd_bad) begin
                            r_state <= S_FAULT;
                            r_fault <= 1'b1;
                        end else begin
                            r_state <= S_HOLD;
                        end
                    end else if (w_tick) begin
                        r_speed <= w_dn[SPEED_W-1:0];
                        r_presc <= '0;
                    end else begin
                        r_presc <= r_presc + PRE_W'(1);
                    end
                end
                S_HOLD: begin
                    if (w_cmd_bad) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end else if (r_hold == HOLD_LAST) begin
                        r_state <= S_IDLE;
                        r_hold  <= '0;
                    end else begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end
                S_FAULT: begin
                    r_speed    <= '0;
                    r_en       <= 1'b0;
                    r_brake    <= 1'b1;
                    r_at_speed <= 1'b0;
                    r_fault    <= 1'b1;
                end
                default: begin
                    r_state <= S_FAULT;
                    r_fault <= 1'b1;
                end
            endcase
        end
    end

    assign speed     = r_speed;
    assign motor_dir = r_dir;
    assign motor_en  = r_en;
    assign brake     = r_brake;
    assign at_speed  = r_at_speed;
    assign fault     = r_fault;

endmodule
